// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ready-based instruction
// memory handshake, absorbs one word in a skid buffer while decode stalls,
// and loads the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSel,
  input  logic [31:0] alu_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_KILL  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_tgt;
  logic [31:0] w_tgt_nxt;
  logic        r_buf_valid;
  logic [31:0] r_buf_inst;
  logic [31:0] r_buf_pc;
  logic [31:0] r_if_inst;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc4;
  logic        r_if_valid;

  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_req;
  logic        w_accept;
  logic        w_buf_load;

  assign w_target   = alu_target & 32'hFFFF_FFFC;
  assign w_pc_plus4 = r_pc + 32'd4;
  // The skid buffer blocks new requests, but a doomed request in KILL must
  // still be allowed to complete so the redirect can be issued.
  assign w_req      = (r_state != S_BOOT) && ((r_state == S_KILL) || !r_buf_valid);
  assign w_accept   = w_req && imem_ready;
  assign w_buf_load = (r_state == S_FETCH) && !PCSel && w_accept && stall;

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign if_id_inst  = r_if_inst;
  assign if_id_pc    = r_if_pc;
  assign if_id_pc4   = r_if_pc4;
  assign if_id_valid = r_if_valid;

  // Next-state, next-PC and pending-target selection.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_tgt_nxt   = r_tgt;
    case (r_state)
      S_BOOT: w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (PCSel) begin
          if (w_accept) begin
            w_pc_nxt = w_target;
          end else begin
            w_tgt_nxt   = w_target;
            w_state_nxt = S_KILL;
          end
        end else if (w_accept) begin
          w_pc_nxt = w_pc_plus4;
        end
      end
      S_KILL: begin
        if (PCSel) w_tgt_nxt = w_target;
        if (w_accept) begin
          w_pc_nxt    = PCSel ? w_target : r_tgt;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // State, PC and pending redirect target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_tgt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_tgt   <= w_tgt_nxt;
    end
  end

  // One-entry skid buffer: captures a word accepted while decode is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
    end else if (PCSel) begin
      r_buf_valid <= 1'b0;
    end else if (w_buf_load) begin
      r_buf_valid <= 1'b1;
      r_buf_inst  <= imem_rdata;
      r_buf_pc    <= r_pc;
    end else if (!stall && r_buf_valid) begin
      r_buf_valid <= 1'b0;
    end
  end

  // IF/ID register: flush, hold, drain buffer, take memory, else bubble.
  always_ff @(posedge clk) begin
    if (rst || PCSel) begin
      r_if_inst  <= NOP_INST;
      r_if_pc    <= '0;
      r_if_pc4   <= '0;
      r_if_valid <= 1'b0;
    end else if (stall) begin
      r_if_inst  <= r_if_inst;
      r_if_pc    <= r_if_pc;
      r_if_pc4   <= r_if_pc4;
      r_if_valid <= r_if_valid;
    end else if (r_buf_valid) begin
      r_if_inst  <= r_buf_inst;
      r_if_pc    <= r_buf_pc;
      r_if_pc4   <= r_buf_pc + 32'd4;
      r_if_valid <= 1'b1;
    end else if ((r_state == S_FETCH) && w_accept) begin
      r_if_inst  <= imem_rdata;
      r_if_pc    <= r_pc;
      r_if_pc4   <= w_pc_plus4;
      r_if_valid <= 1'b1;
    end else begin
      r_if_inst  <= NOP_INST;
      r_if_pc    <= '0;
      r_if_pc4   <= '0;
      r_if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a wait-programmable instruction memory returning
// addr^A5A5_0000, a procedural reference model of the fetch rules, and
// directed scenarios with literal checkpoints.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, PCSel, stall, imem_ready;
  logic [31:0] alu_target, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_inst, if_id_pc, if_id_pc4;

  int n_tests = 0;
  int n_fail  = 0;
  int mem_wait = 0;
  int wcnt     = 0;

  // reference model state
  bit          m_valid = 1'b0;
  bit          m_boot, m_kill;
  logic [31:0] m_pc, m_tgt;
  logic [31:0] q_inst[$];
  logic [31:0] q_pc[$];
  logic [31:0] e_inst, e_pc, e_pc4;
  logic        e_valid;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .PCSel(PCSel), .alu_target(alu_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .if_id_inst(if_id_inst), .if_id_pc(if_id_pc),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic m_req;
    m_req = !m_boot && (m_kill || q_inst.size() == 0);
    chk("m_req",   imem_req,    m_req);
    chk("m_addr",  imem_addr,   m_pc);
    chk("m_inst",  if_id_inst,  e_inst);
    chk("m_pc",    if_id_pc,    e_pc);
    chk("m_pc4",   if_id_pc4,   e_pc4);
    chk("m_valid", if_id_valid, e_valid);
  endtask

  task automatic set_bubble();
    e_inst = NOP; e_pc = '0; e_pc4 = '0; e_valid = 1'b0;
  endtask

  task automatic model_update();
    logic        m_req, acc;
    logic [31:0] tgt;
    m_req = !m_boot && (m_kill || q_inst.size() == 0);
    acc   = m_req && imem_ready;
    tgt   = alu_target & 32'hFFFF_FFFC;
    if (rst) begin
      m_valid = 1'b1; m_boot = 1'b1; m_kill = 1'b0; m_pc = 32'h0;
      q_inst.delete(); q_pc.delete();
      set_bubble();
      return;
    end
    if (!m_valid) return;
    // decode-side register
    if (PCSel) begin
      set_bubble();
      q_inst.delete(); q_pc.delete();
    end else if (stall) begin
      // hold
    end else if (q_inst.size() > 0) begin
      e_inst = q_inst.pop_front(); e_pc = q_pc.pop_front();
      e_pc4 = e_pc + 32'd4; e_valid = 1'b1;
    end else if (!m_boot && !m_kill && acc) begin
      e_inst = imem_rdata; e_pc = m_pc; e_pc4 = m_pc + 32'd4; e_valid = 1'b1;
    end else begin
      set_bubble();
    end
    // program counter side
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_kill) begin
      if (PCSel) m_tgt = tgt;
      if (acc) begin m_pc = m_tgt; m_kill = 1'b0; end
    end else if (PCSel) begin
      if (acc) m_pc = tgt;
      else begin m_tgt = tgt; m_kill = 1'b1; end
    end else if (acc) begin
      if (stall) begin q_inst.push_back(imem_rdata); q_pc.push_back(m_pc); end
      m_pc = m_pc + 32'd4;
    end
  endtask

  // One clock cycle: memory responds, outputs compared, edge, model advances.
  task automatic cyc();
    bit hold;
    if (imem_req === 1'b1 && wcnt >= mem_wait) begin
      imem_ready = 1'b1; imem_rdata = imem_addr ^ KEY;
    end else begin
      imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    end
    hold = (imem_req === 1'b1) && !imem_ready;
    if (m_valid) model_check();
    @(posedge clk);
    model_update();
    wcnt = hold ? wcnt + 1 : 0;
    #1;
  endtask

  initial begin
    logic [31:0] spat;
    spat = 32'b0011_0100_1110_0001_1000_1011_0001_1100;
    rst = 1'b1; PCSel = 1'b0; stall = 1'b0; alu_target = '0;
    imem_ready = 1'b0; imem_rdata = '0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_req",   imem_req,    32'h0);
    chk("rst_addr",  imem_addr,   32'h0);
    chk("rst_inst",  if_id_inst,  32'h0000_0013);
    chk("rst_pc",    if_id_pc,    32'h0);
    chk("rst_pc4",   if_id_pc4,   32'h0);
    chk("rst_valid", if_id_valid, 32'h0);
    cyc();
    chk("first_req", imem_req, 32'h1);
    cyc();
    chk("seq0_pc",    if_id_pc,    32'h0);
    chk("seq0_inst",  if_id_inst,  32'hA5A5_0000);
    chk("seq0_valid", if_id_valid, 32'h1);
    cyc();
    chk("seq1_pc",   if_id_pc,   32'h4);
    chk("seq1_inst", if_id_inst, 32'hA5A5_0004);
    cyc();
    chk("seq2_pc",   if_id_pc,   32'h8);
    chk("seq2_inst", if_id_inst, 32'hA5A5_0008);
    cyc();
    // taken branch from pc 0x10
    chk("br_at", imem_addr, 32'h10);
    PCSel = 1'b1; alu_target = 32'h0000_0103;
    cyc();
    PCSel = 1'b0; alu_target = '0;
    chk("br_addr",   imem_addr,   32'h100);
    chk("br_bubble", if_id_valid, 32'h0);
    cyc();
    chk("br_pc", if_id_pc, 32'h100);
    // redirect during a 3-cycle wait on 0x104
    mem_wait = 3; PCSel = 1'b1; alu_target = 32'h200;
    cyc();
    PCSel = 1'b0; alu_target = '0;
    chk("kill_hold1", imem_addr, 32'h104);
    cyc();
    chk("kill_hold2", imem_addr, 32'h104);
    cyc();
    chk("kill_hold3", imem_addr, 32'h104);
    cyc();
    chk("kill_tgt",  imem_addr,   32'h200);
    chk("kill_drop", if_id_valid, 32'h0);
    mem_wait = 0;
    cyc();
    chk("kill_pc", if_id_pc, 32'h200);
    // four stall cycles with a ready memory
    stall = 1'b1;
    cyc();
    chk("stall_req",  imem_req, 32'h0);
    chk("stall_hold", if_id_pc, 32'h200);
    cyc(); cyc(); cyc();
    stall = 1'b0;
    cyc();
    chk("drain_pc",   if_id_pc,   32'h204);
    chk("drain_inst", if_id_inst, 32'hA5A5_0204);
    cyc();
    chk("after_pc", if_id_pc, 32'h208);
    // PC wrap
    PCSel = 1'b1; alu_target = 32'hFFFF_FFFC;
    cyc();
    PCSel = 1'b0; alu_target = '0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_pc",   if_id_pc,  32'hFFFF_FFFC);
    chk("wrap_pc4",  if_id_pc4, 32'h0);
    chk("wrap_next", imem_addr, 32'h0);
    cyc(); cyc();
    // reset in the cycle the response arrives
    chk("rmid_addr", imem_addr, 32'h8);
    mem_wait = 2;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; mem_wait = 0;
    chk("rmid_req",   imem_req,    32'h0);
    chk("rmid_addr0", imem_addr,   32'h0);
    chk("rmid_valid", if_id_valid, 32'h0);
    cyc(); cyc(); cyc();
    // stall and flush together: flush wins
    stall = 1'b1; PCSel = 1'b1; alu_target = 32'h80;
    cyc();
    stall = 1'b0; PCSel = 1'b0; alu_target = '0;
    chk("sf_valid", if_id_valid, 32'h0);
    chk("sf_addr",  imem_addr,   32'h80);
    chk("sf_req",   imem_req,    32'h1);
    // mixed stall / wait / redirect traffic, checked by the model
    for (int i = 0; i < 32; i++) begin
      stall      = spat[i];
      mem_wait   = i % 3;
      PCSel      = (i == 9 || i == 21);
      alu_target = 32'h300 + 32'(i * 16);
      cyc();
    end
    stall = 1'b0; PCSel = 1'b0; alu_target = '0; mem_wait = 0;
    repeat (4) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32I core. Owns the program counter, fetches instructions through a ready-based instruction-memory handshake, and presents them to decode through the IF/ID pipeline register. Redirects arrive from the execute stage as `PCSel` plus the ALU-computed target. Stalls arrive from the hazard unit. A one-entry skid buffer keeps a fetched word from being lost while decode is stalled.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded by reset.
- `NOP_INST`, 32'h0000_0013 (`addi x0,x0,0`), instruction driven into IF/ID on bubble or flush.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `PCSel`  in  1  redirect request from EX (taken branch, JAL, JALR).
- `alu_target`  in  32  redirect target; bits [1:0] are forced to 0 internally.
- `stall`  in  1  hazard stall; holds IF/ID contents.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; held stable while `imem_req`=1 and `imem_ready`=0.
- `imem_rdata`  in  32  instruction word; valid when `imem_ready`=1.
- `imem_ready`  in  1  completes the current request this cycle. Memory asserts it only while `imem_req`=1.
- `if_id_inst`  out  32  registered instruction to decode/controller.
- `if_id_pc`  out  32  PC of `if_id_inst`.
- `if_id_pc4`  out  32  `if_id_pc`+4 (JAL/JALR link value).
- `if_id_valid`  out  1  1 = real instruction, 0 = bubble.

## Operation
- Registers: `pc`, `state`, `tgt_q` (pending redirect target), skid buffer `{buf_valid, buf_inst, buf_pc}`, and the IF/ID register.
- States:
  - BOOT: `imem_req`=0. Always moves to FETCH next cycle.
  - FETCH: normal fetching.
  - KILL: the in-flight request is doomed because of a redirect; its data will be discarded.
- Outputs:
  - `imem_addr`=`pc` in every state.
  - `imem_req` = (state≠BOOT) && (state==KILL || !buf_valid).
- FETCH, with "accept" meaning `imem_req`&&`imem_ready`:
  - `PCSel` && accept: discard `imem_rdata`; `pc`<=target; stay in FETCH.
  - `PCSel` && !accept: `tgt_q`<=target; go to KILL. `pc` is unchanged, so the pending address stays stable.
  - !`PCSel` && accept && !`stall` && !buf_valid: IF/ID<={rdata, pc, pc+4, 1}; `pc`<=pc+4.
  - !`PCSel` && accept && `stall`: the word goes into the skid buffer (buf_valid<=1); `pc`<=pc+4.
- KILL:
  - Any further `PCSel` overwrites `tgt_q` (latest wins).
  - On accept: discard data; `pc`<=`tgt_q` (or the new target if `PCSel` is high the same cycle); go to FETCH.
- IF/ID update, in priority order:
  1. `PCSel`: load {NOP_INST, 0, 0, 0} and clear buf_valid. A flush overrides `stall`.
  2. `stall`: hold all IF/ID fields.
  3. buf_valid: load from the buffer and clear buf_valid.
  4. FETCH accept: load from memory.
  5. Otherwise: load a bubble {NOP_INST, 0, 0, 0}.
- Arithmetic: all PC sums are 32-bit and wrap modulo 2^32. 32'hFFFF_FFFC+4 = 0.
- Reset (`rst`=1 at an edge, any state, including mid-request):
  - `pc`<=RESET_PC, state<=BOOT, buf_valid<=0.
  - IF/ID<={NOP_INST, 0, 0, 0}.
  - Any outstanding memory response is ignored, because BOOT drives `imem_req`=0.

## Timing
- Values after reset:
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `if_id_inst`=NOP_INST, `if_id_pc`=0, `if_id_pc4`=0, `if_id_valid`=0.
- First request: `imem_req`=1 in the 2nd cycle after `rst` deasserts.
- Latency: accept in cycle N makes `if_id_valid`=1 in cycle N+1.
- Throughput: a zero-wait memory (`imem_ready` tied to `imem_req`) sustains 1 instruction/cycle.
- Redirect:
  - `PCSel` in cycle N with no pending wait: `imem_addr`=target in N+1, and IF/ID holds a bubble in N+1.
  - `PCSel` during a wait: target issued the cycle after the doomed request completes.
- Stall: the buffer holds at most 1 word. `imem_req` stays 0 while buf_valid=1, except in KILL. A stall never retracts a pending request.
- `stall` and `PCSel` in the same cycle: the flush wins.

## Test plan
- Reset, then zero-wait memory returning `addr^32'hA5A5_0000`: IF/ID pc = 0, 4, 8 on consecutive cycles, each with matching inst and `if_id_valid`=1.
- Taken branch: `PCSel`=1, `alu_target`=32'h0000_0103 while at pc 0x10. Next cycle `imem_addr`=0x100 and IF/ID is a bubble; two cycles later `if_id_pc`=0x100.
- Redirect during a 3-cycle wait: `PCSel` with target 0x200 in wait cycle 1. `imem_addr` stays at the old pc until ready, that data never reaches IF/ID, and the next request is to 0x200.
- Stall for 4 cycles with ready every cycle: exactly one word is buffered and `imem_req` drops. On release, the buffered pc appears first, then pc+4; no skip and no duplicate.
- PC wrap: `alu_target`=0xFFFF_FFFC then sequential fetch gives `if_id_pc4`=0 and next `imem_addr`=0.
- Reset asserted mid-wait with ready arriving the same cycle: data discarded, `imem_req`=0 the next cycle, `imem_addr`=RESET_PC.
